// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ready channel between the fetch stage
// (master) and the instruction memory (slave).
interface fetch_stage_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  imem_req;
  logic [DATA_WIDTH-1:0] imem_addr;
  logic                  imem_ready;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic                  imem_waitF;

  modport master (
    output imem_req,
    output imem_addr,
    output imem_waitF,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    input  imem_waitF,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// IF stage with IF/ID register: owns the PC, runs the imem handshake,
// applies D-stage redirects and hazard-unit stalls.
module fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    PC_INC     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stallF,
  input  logic                  stallD,
  input  logic                  pcsrcD,
  input  logic [DATA_WIDTH-1:0] pcbranchD,
  input  logic                  jumpD,
  input  logic [DATA_WIDTH-1:0] pcjumpD,
  fetch_stage_if.master         imem,
  output logic [DATA_WIDTH-1:0] instrD,
  output logic [DATA_WIDTH-1:0] pcplus4D,
  output logic                  validD
);

  localparam logic [DATA_WIDTH-1:0] INC = DATA_WIDTH'(PC_INC);

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    WAIT_RD
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] pcF;
  logic [DATA_WIDTH-1:0] pendTgt;
  logic [DATA_WIDTH-1:0] target;
  logic [DATA_WIDTH-1:0] pcNext;
  logic                  redirect;
  logic                  ready;

  assign ready    = imem.imem_ready;
  assign redirect = ~stallD & (jumpD | pcsrcD);
  assign target   = jumpD ? pcjumpD : pcbranchD;
  assign pcNext   = pcF + INC;

  assign imem.imem_req   = ~reset;
  assign imem.imem_addr  = pcF;
  assign imem.imem_waitF = imem.imem_req & ~ready;

  // pcF only moves on a ready cycle so the address is stable mid-request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FETCH;
      pcF     <= RESET_PC;
      pendTgt <= '0;
    end else begin
      unique case (state)
        FETCH, WAIT: begin
          if (ready) begin
            state <= FETCH;
            if (!stallF)
              pcF <= redirect ? target : pcNext;
          end else if (redirect) begin
            pendTgt <= target;
            state   <= WAIT_RD;
          end else begin
            state <= WAIT;
          end
        end
        WAIT_RD: begin
          if (ready) begin
            pcF   <= redirect ? target : pendTgt;
            state <= FETCH;
          end else if (redirect) begin
            pendTgt <= target;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  // A ready while stallF holds re-requests the same word, so it is not loaded
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instrD   <= '0;
      pcplus4D <= '0;
      validD   <= 1'b0;
    end else if (stallD) begin
      instrD   <= instrD;
      pcplus4D <= pcplus4D;
      validD   <= validD;
    end else if (redirect) begin
      instrD   <= '0;
      pcplus4D <= '0;
      validD   <= 1'b0;
    end else if (ready && state != WAIT_RD && !stallF) begin
      instrD   <= imem.imem_rdata;
      pcplus4D <= pcNext;
      validD   <= 1'b1;
    end else begin
      instrD   <= '0;
      pcplus4D <= '0;
      validD   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a transaction-level model of
// the fetch pipeline (next fetch address, wrong-path flag, D register).
module tb_fetch_stage;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          stallF, stallD, pcsrcD, jumpD;
  logic [DW-1:0] pcbranchD, pcjumpD;
  logic [DW-1:0] instrD, pcplus4D;
  logic          validD;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mPc, mPend, mInstr, mPc4;
  bit            mDiscard, mValid;

  fetch_stage_if #(.DATA_WIDTH(DW)) imem ();

  fetch_stage #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .stallF    (stallF),
    .stallD    (stallD),
    .pcsrcD    (pcsrcD),
    .pcbranchD (pcbranchD),
    .jumpD     (jumpD),
    .pcjumpD   (pcjumpD),
    .imem      (imem),
    .instrD    (instrD),
    .pcplus4D  (pcplus4D),
    .validD    (validD)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] memWord(input logic [DW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0001;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    mPc      = '0;
    mPend    = '0;
    mDiscard = 0;
    mInstr   = '0;
    mPc4     = '0;
    mValid   = 0;
  endtask

  // Starts and ends at a falling edge: drive, check, clock, update model.
  task automatic tick(input bit sF, input bit sD, input bit ps,
                      input logic [DW-1:0] pb, input bit j,
                      input logic [DW-1:0] pj, input bit rdy);
    bit            redir;
    logic [DW-1:0] tgt;
    stallF    = sF;
    stallD    = sD;
    pcsrcD    = ps;
    pcbranchD = pb;
    jumpD     = j;
    pcjumpD   = pj;
    imem.imem_ready = rdy;
    imem.imem_rdata = rdy ? memWord(imem.imem_addr) : 32'hDEAD_BEEF;
    #1;
    chk("req", {31'b0, imem.imem_req}, 1);
    chk("addr", imem.imem_addr, mPc);
    chk("waitF", {31'b0, imem.imem_waitF}, {31'b0, !rdy});
    chk("instrD", instrD, mInstr);
    chk("pcplus4D", pcplus4D, mPc4);
    chk("validD", {31'b0, validD}, {31'b0, mValid});
    @(posedge clk);
    redir = !sD && (j || ps);
    tgt   = j ? pj : pb;
    if (!sD) begin
      if (!redir && rdy && !mDiscard && !sF) begin
        mInstr = memWord(mPc);
        mPc4   = mPc + 32'd4;
        mValid = 1;
      end else begin
        mInstr = '0;
        mPc4   = '0;
        mValid = 0;
      end
    end
    if (rdy) begin
      if (mDiscard)
        mPc = redir ? tgt : mPend;
      else if (!sF)
        mPc = redir ? tgt : mPc + 32'd4;
      mDiscard = 0;
    end else if (redir) begin
      mDiscard = 1;
      mPend    = tgt;
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit rdy);
    tick(0, 0, 0, '0, 0, '0, rdy);
  endtask

  task automatic checkReset(input string tag);
    chk({tag, "_req"}, {31'b0, imem.imem_req}, 0);
    chk({tag, "_addr"}, imem.imem_addr, '0);
    chk({tag, "_instr"}, instrD, '0);
    chk({tag, "_pc4"}, pcplus4D, '0);
    chk({tag, "_valid"}, {31'b0, validD}, 0);
  endtask

  initial begin
    reset = 1'b1;
    stallF = 0; stallD = 0; pcsrcD = 0; jumpD = 0;
    pcbranchD = '0; pcjumpD = '0;
    imem.imem_ready = 1'b1;
    imem.imem_rdata = '0;
    modelReset();
    #12;
    checkReset("rst");
    @(negedge clk);
    reset = 1'b0;

    repeat (2) idle(1);
    repeat (2) tick(1, 1, 0, '0, 0, '0, 1);
    repeat (3) idle(1);
    tick(0, 0, 0, '0, 1, 32'h10, 1);
    tick(0, 0, 1, 32'h40, 0, '0, 1);
    repeat (2) idle(1);
    tick(0, 0, 1, 32'h40, 1, 32'h80, 1);
    idle(1);
    tick(1, 1, 1, 32'h40, 1, 32'h80, 1);
    idle(1);
    tick(0, 0, 0, '0, 1, 32'h20, 1);
    repeat (3) idle(0);
    repeat (2) idle(1);
    tick(0, 0, 0, '0, 1, 32'h20, 1);
    idle(0);
    tick(0, 0, 1, 32'h100, 0, '0, 0);
    idle(0);
    repeat (3) idle(1);
    tick(0, 0, 0, '0, 1, 32'hFFFF_FFFC, 1);
    repeat (3) idle(1);

    for (int i = 0; i < 2000; i++) begin
      bit sD;
      sD = ($urandom % 7) == 0;
      tick(sD, sD, ($urandom % 5) == 0, {$urandom, 2'b00} >> 0,
           ($urandom % 8) == 0, {$urandom, 2'b00} >> 0,
           ($urandom % 10) < 7);
    end

    repeat (2) idle(1);
    imem.imem_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checkReset("midrst");
    @(negedge clk);
    checkReset("rsthold");
    reset = 1'b0;
    modelReset();
    repeat (4) idle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
